// File: rtl/led_display_bcm_driver.sv
// HUB75-style panel driver: two half-panel shift channels with binary-coded modulation.
// Pixels are fetched from a frame buffer with a fixed one-cycle read latency.
module led_display_bcm_driver #(
   parameter int SYS_CLK_FREQ   = 100_000_000,
   parameter int NUM_ROW_PIXELS = 32,
   parameter int NUM_COL_PIXELS = 64,
   parameter int COLOUR_DEPTH   = 4,
   parameter int BCLK_DIV       = 4,
   parameter int BASE_ON_CYCLES = 16,
   parameter int LATCH_CYCLES   = 2
) (
   input  logic                                                  clk_in,
   input  logic                                                  reset_in,
   input  logic                                                  enable_in,
   output logic                                                  rd_en_out,
   output logic [$clog2(NUM_ROW_PIXELS/2*NUM_COL_PIXELS)-1:0]    rd_addr_out,
   input  logic [6*COLOUR_DEPTH-1:0]                             rd_data_in,
   output logic [5:0]                                            rgb_out,
   output logic                                                  bclk_out,
   output logic                                                  latch_out,
   output logic                                                  oe_n_out,
   output logic [$clog2(NUM_ROW_PIXELS/2)-1:0]                   row_addr_out,
   output logic                                                  busy_out,
   output logic                                                  frame_start_out,
   output logic                                                  frame_done_out
);

   localparam int SCAN_ROWS = NUM_ROW_PIXELS / 2;
   localparam int ADDR_W    = $clog2(SCAN_ROWS * NUM_COL_PIXELS);
   localparam int ROW_W     = $clog2(SCAN_ROWS);
   localparam int COL_W     = $clog2(NUM_COL_PIXELS);
   localparam int PH_W      = $clog2(BCLK_DIV);
   localparam int PL_W      = (COLOUR_DEPTH > 1) ? $clog2(COLOUR_DEPTH) : 1;
   localparam int MAX_ON    = BASE_ON_CYCLES << (COLOUR_DEPTH - 1);
   localparam int ON_W      = $clog2(MAX_ON + 1);
   localparam int LAT_W     = $clog2(LATCH_CYCLES + 1);

   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BCLK_DIV - 1);
   localparam logic [PH_W-1:0]  PH_PRE   = PH_W'(BCLK_DIV - 2);
   localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(BCLK_DIV / 2);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COL_PIXELS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SCAN_ROWS - 1);
   localparam logic [PL_W-1:0]  PL_LAST  = PL_W'(COLOUR_DEPTH - 1);
   localparam logic [ON_W-1:0]  BASE_ON  = ON_W'(BASE_ON_CYCLES);
   localparam logic [LAT_W-1:0] LAT_LEN  = LAT_W'(LATCH_CYCLES);

   if (SYS_CLK_FREQ <= 0 || NUM_ROW_PIXELS < 4 || (NUM_ROW_PIXELS % 2) != 0 ||
       NUM_COL_PIXELS < 2 || COLOUR_DEPTH < 1 || COLOUR_DEPTH > 8 ||
       BCLK_DIV < 2 || (BCLK_DIV % 2) != 0 || BASE_ON_CYCLES < 1 || LATCH_CYCLES < 1) begin : g_bad_cfg
      $error("led_display_bcm_driver: unsupported parameter set");
   end

   typedef enum logic [2:0] {IDLE, PREFETCH, SHIFT, BLANK, LATCH, DISPLAY} state_t;

   state_t             state_q;
   logic [ROW_W-1:0]   row_q;
   logic [PL_W-1:0]    plane_q;
   logic [COL_W-1:0]   col_q;
   logic [PH_W-1:0]    phase_q;
   logic [ON_W-1:0]    on_cnt_q;
   logic [LAT_W-1:0]   lat_cnt_q;
   logic               rd_en_q;
   logic [ADDR_W-1:0]  rd_addr_q;
   logic [5:0]         rgb_q;
   logic               bclk_q;
   logic               latch_q;
   logic               oe_n_q;
   logic [ROW_W-1:0]   row_addr_q;
   logic               frame_start_q;
   logic               frame_done_q;

   logic [5:0]         rgb_sel;
   logic [ON_W-1:0]    on_len;
   logic               last_slot;

   // Bit [plane] of each of the six colour channels, channel 0 in the LSBs.
   for (genvar g = 0; g < 6; g++) begin : g_sel
      logic [COLOUR_DEPTH-1:0] chan;
      assign chan       = rd_data_in[g*COLOUR_DEPTH +: COLOUR_DEPTH];
      assign rgb_sel[g] = chan[plane_q];
   end

   assign on_len    = BASE_ON << plane_q;
   assign last_slot = (row_q == ROW_LAST) && (plane_q == PL_LAST);

   function automatic logic [ADDR_W-1:0] addr_of(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
      return ADDR_W'(int'(r) * NUM_COL_PIXELS + int'(c));
   endfunction

   // Every output is registered: each branch sets the values seen during the next state.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q       <= IDLE;
         row_q         <= '0;
         plane_q       <= '0;
         col_q         <= '0;
         phase_q       <= '0;
         on_cnt_q      <= '0;
         lat_cnt_q     <= '0;
         rd_en_q       <= 1'b0;
         rd_addr_q     <= '0;
         rgb_q         <= '0;
         bclk_q        <= 1'b0;
         latch_q       <= 1'b0;
         oe_n_q        <= 1'b1;
         row_addr_q    <= '0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         rd_en_q       <= 1'b0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (enable_in) begin
                  state_q       <= PREFETCH;
                  row_q         <= '0;
                  plane_q       <= '0;
                  rd_en_q       <= 1'b1;
                  rd_addr_q     <= '0;
                  frame_start_q <= 1'b1;
               end
            end
            PREFETCH: begin
               state_q <= SHIFT;
               col_q   <= '0;
               phase_q <= '0;
               bclk_q  <= 1'b0;
            end
            SHIFT: begin
               if (phase_q == '0) rgb_q <= rgb_sel;
               // Issue the next column's read so its data lands on that column's phase 0.
               if (phase_q == PH_PRE && col_q != COL_LAST) begin
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= addr_of(row_q, col_q + COL_W'(1));
               end
               if (phase_q == PH_LAST) begin
                  phase_q <= '0;
                  bclk_q  <= 1'b0;
                  if (col_q == COL_LAST) begin
                     state_q    <= BLANK;
                     row_addr_q <= row_q;
                  end else begin
                     col_q <= col_q + COL_W'(1);
                  end
               end else begin
                  phase_q <= phase_q + PH_W'(1);
                  bclk_q  <= (phase_q + PH_W'(1)) >= PH_HALF;
               end
            end
            BLANK: begin
               state_q   <= LATCH;
               latch_q   <= 1'b1;
               lat_cnt_q <= LAT_LEN;
            end
            LATCH: begin
               if (lat_cnt_q == LAT_W'(1)) begin
                  state_q      <= DISPLAY;
                  latch_q      <= 1'b0;
                  oe_n_q       <= 1'b0;
                  on_cnt_q     <= on_len;
                  frame_done_q <= last_slot && (on_len == ON_W'(1));
               end else begin
                  lat_cnt_q <= lat_cnt_q - LAT_W'(1);
               end
            end
            DISPLAY: begin
               if (on_cnt_q == ON_W'(1)) begin
                  oe_n_q <= 1'b1;
                  if (plane_q != PL_LAST) begin
                     plane_q   <= plane_q + PL_W'(1);
                     state_q   <= PREFETCH;
                     rd_en_q   <= 1'b1;
                     rd_addr_q <= addr_of(row_q, '0);
                  end else begin
                     plane_q <= '0;
                     if (row_q != ROW_LAST) begin
                        row_q     <= row_q + ROW_W'(1);
                        state_q   <= PREFETCH;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= addr_of(row_q + ROW_W'(1), '0);
                     end else begin
                        row_q     <= '0;
                        rd_addr_q <= '0;
                        if (enable_in) begin
                           state_q       <= PREFETCH;
                           rd_en_q       <= 1'b1;
                           frame_start_q <= 1'b1;
                        end else begin
                           state_q    <= IDLE;
                           rgb_q      <= '0;
                           row_addr_q <= '0;
                        end
                     end
                  end
               end else begin
                  on_cnt_q     <= on_cnt_q - ON_W'(1);
                  frame_done_q <= last_slot && (on_cnt_q == ON_W'(2));
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rd_en_out       = rd_en_q;
   assign rd_addr_out     = rd_addr_q;
   assign rgb_out         = rgb_q;
   assign bclk_out        = bclk_q;
   assign latch_out       = latch_q;
   assign oe_n_out        = oe_n_q;
   assign row_addr_out    = row_addr_q;
   assign busy_out        = (state_q != IDLE);
   assign frame_start_out = frame_start_q;
   assign frame_done_out  = frame_done_q;

endmodule

// File: tb/tb_led_display_bcm_driver.sv
// Scoreboard bench: a small-config instance and a default-config instance share one clock.
module tb_led_display_bcm_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- small instance ----------------
   logic        rst_a = 1'b1, en_a = 1'b0;
   logic        rd_en_a, bclk_a, latch_a, oe_n_a, busy_a, fs_a, fd_a;
   logic [2:0]  rd_addr_a;
   logic [11:0] rd_data_a = '0;
   logic [5:0]  rgb_a;
   logic [0:0]  row_addr_a;

   led_display_bcm_driver #(
      .NUM_ROW_PIXELS(4), .NUM_COL_PIXELS(4), .COLOUR_DEPTH(2),
      .BCLK_DIV(2), .BASE_ON_CYCLES(4), .LATCH_CYCLES(1)
   ) u_small (
      .clk_in(clk), .reset_in(rst_a), .enable_in(en_a),
      .rd_en_out(rd_en_a), .rd_addr_out(rd_addr_a), .rd_data_in(rd_data_a),
      .rgb_out(rgb_a), .bclk_out(bclk_a), .latch_out(latch_a), .oe_n_out(oe_n_a),
      .row_addr_out(row_addr_a), .busy_out(busy_a),
      .frame_start_out(fs_a), .frame_done_out(fd_a)
   );

   // Buffer word at r*4+c: upper R = c, lower B = r+1, everything else 0.
   always @(posedge clk) if (rd_en_a) rd_data_a <= {2'(rd_addr_a[2] + 1), 8'b0, rd_addr_a[1:0]};

   // ---------------- default instance ----------------
   logic        rst_b = 1'b1, en_b = 1'b0;
   logic        rd_en_b, bclk_b, latch_b, oe_n_b, busy_b, fs_b, fd_b;
   logic [9:0]  rd_addr_b;
   logic [23:0] rd_data_b = '0;
   logic [5:0]  rgb_b;
   logic [3:0]  row_addr_b;

   led_display_bcm_driver u_dflt (
      .clk_in(clk), .reset_in(rst_b), .enable_in(en_b),
      .rd_en_out(rd_en_b), .rd_addr_out(rd_addr_b), .rd_data_in(rd_data_b),
      .rgb_out(rgb_b), .bclk_out(bclk_b), .latch_out(latch_b), .oe_n_out(oe_n_b),
      .row_addr_out(row_addr_b), .busy_out(busy_b),
      .frame_start_out(fs_b), .frame_done_out(fd_b)
   );

   always @(posedge clk) if (rd_en_b) rd_data_b <= {4'hA, rd_addr_b, rd_addr_b};

   // ---------------- scoreboards ----------------
   logic [5:0] q_rgb_a[$];
   int         q_oe_a[$];
   int         q_row_b[$];
   int         q_done_b[$];

   // Monitor A
   int unsigned last_fs_a = 0;
   int  fs_cnt_a = 0, fd_cnt_a = 0, oe_run_a = 0, edges_a = 0;
   bit  fs_seen_a = 0, prev_bclk_a = 0, prev_latch_a = 0;
   always begin
      @(posedge clk); #1;
      if (!rst_a) begin
         if (fs_a) begin
            if (fs_seen_a) begin
               chk("a_frame_period", cyc - last_fs_a, 68);
               chk("a_done_per_frame", fd_cnt_a, 1);
            end
            fs_seen_a = 1; last_fs_a = cyc; fd_cnt_a = 0; fs_cnt_a++;
         end
         if (fd_a) fd_cnt_a++;
         if (!oe_n_a) oe_run_a++;
         else if (oe_run_a != 0) begin
            if (q_oe_a.size() == 0) begin
               total++; bad++;
               $display("FAIL a_oe_extra: got low run %0d, none expected", oe_run_a);
            end else chk("a_oe_len", oe_run_a, q_oe_a.pop_front());
            oe_run_a = 0;
         end
         if (bclk_a && !prev_bclk_a) begin
            if (q_rgb_a.size() == 0) begin
               total++; bad++;
               $display("FAIL a_rgb_extra: got rgb %0d at unexpected bclk edge", rgb_a);
            end else chk("a_rgb", rgb_a, q_rgb_a.pop_front());
            edges_a++;
         end
         if (latch_a && !prev_latch_a) begin
            chk("a_edges_per_plane", edges_a, 4);
            chk("a_latch_oe", oe_n_a, 1);
            edges_a = 0;
         end
         prev_bclk_a  = bclk_a;
         prev_latch_a = latch_a;
      end
   end

   // Monitor B
   int  rd_cnt_b = 0, prev_addr_b = 0, lat_cnt_b = 0, fs_cnt_b = 0, done_exp_b = 0;
   bit  prev_latch_b = 0, done_pend_b = 0;
   always begin
      @(posedge clk); #1;
      if (rst_b) begin
         rd_cnt_b = 0; lat_cnt_b = 0; prev_latch_b = 0; done_pend_b = 0;
      end else begin
         if (done_pend_b) begin
            chk("b_busy_after_done", busy_b, done_exp_b);
            done_pend_b = 0;
         end
         if (fs_b) begin fs_cnt_b++; lat_cnt_b = 0; end
         if (fd_b) begin
            if (q_done_b.size() == 0) begin
               total++; bad++;
               $display("FAIL b_done_extra: got frame_done_out=%0d, no frame end expected", fd_b);
            end else begin
               done_exp_b = q_done_b.pop_front(); done_pend_b = 1;
            end
         end
         if (rd_en_b) begin
            if (rd_cnt_b == 0) begin
               if (q_row_b.size() != 0) chk("b_rd_addr_first", rd_addr_b, q_row_b[0] * 64);
            end else chk("b_rd_addr_inc", rd_addr_b, prev_addr_b + 1);
            prev_addr_b = rd_addr_b;
            rd_cnt_b++;
         end
         if (latch_b && !prev_latch_b) begin
            chk("b_reads_per_plane", rd_cnt_b, 64);
            chk("b_latch_oe", oe_n_b, 1);
            if (q_row_b.size() == 0) begin
               total++; bad++;
               $display("FAIL b_latch_extra: got latch at row %0d, none expected", row_addr_b);
            end else chk("b_row_addr", row_addr_b, q_row_b.pop_front());
            rd_cnt_b = 0;
            lat_cnt_b++;
         end
         prev_latch_b = latch_b;
      end
   end

   // ---------------- stimulus ----------------
   task automatic push_frame_b(input bit expect_end, input int busy_after);
      for (int r = 0; r < 16; r++)
         for (int p = 0; p < 4; p++) q_row_b.push_back(r);
      if (expect_end) q_done_b.push_back(busy_after);
   endtask

   task automatic run_a();
      logic [5:0] e;
      int k;
      for (int f = 0; f < 3; f++)
         for (int r = 0; r < 2; r++)
            for (int p = 0; p < 2; p++) begin
               q_oe_a.push_back(4 << p);
               for (int c = 0; c < 4; c++) begin
                  e    = '0;
                  e[5] = 1'(((r + 1) >> p) & 1);
                  e[0] = 1'((c >> p) & 1);
                  q_rgb_a.push_back(e);
               end
            end
      @(negedge clk); en_a = 1'b1;
      for (k = 0; k < 400 && fs_cnt_a < 3; k++) @(negedge clk);
      chk("a_third_frame_start", fs_cnt_a, 3);
      en_a = 1'b0;
      for (k = 0; k < 200 && busy_a; k++) @(negedge clk);
      chk("a_idle", busy_a, 0);
      chk("a_frame_count", fs_cnt_a, 3);
      chk("a_last_frame_done", fd_cnt_a, 1);
      chk("a_rgb_left", q_rgb_a.size(), 0);
      chk("a_oe_left", q_oe_a.size(), 0);
   endtask

   task automatic run_b();
      int k;
      bit found;
      // single frame from a one-cycle enable
      push_frame_b(1, 0);
      @(negedge clk); en_b = 1'b1;
      @(negedge clk); en_b = 1'b0;
      chk("b1_busy_start", busy_b, 1);
      for (k = 0; k < 22000 && busy_b; k++) @(negedge clk);
      chk("b1_idle", busy_b, 0);
      chk("b1_rows_left", q_row_b.size(), 0);
      chk("b1_done_left", q_done_b.size(), 0);
      chk("b1_row_addr_idle", row_addr_b, 0);

      // reset during DISPLAY of row 5
      push_frame_b(0, 0);
      en_b = 1'b1;
      found = 0;
      for (k = 0; k < 9000 && !found; k++) begin
         @(negedge clk);
         found = (!oe_n_b && row_addr_b == 4'd5);
      end
      chk("b2_row5_display", found, 1);
      rst_b = 1'b1;
      @(posedge clk); #1;
      chk("b2_rst_oe", oe_n_b, 1);
      chk("b2_rst_outs", {rd_en_b, rd_addr_b, rgb_b, bclk_b, latch_b, row_addr_b, busy_b, fs_b, fd_b}, 0);
      q_row_b.delete();
      @(negedge clk);
      rst_b = 1'b0;
      push_frame_b(1, 0);

      // restart with enable high, then drop enable at row 3 plane 2
      found = 0;
      for (k = 0; k < 8000 && !found; k++) begin
         @(negedge clk);
         found = (lat_cnt_b >= 15);
      end
      chk("b3_reach_row3_plane2", found, 1);
      en_b = 1'b0;
      for (k = 0; k < 22000 && busy_b; k++) @(negedge clk);
      chk("b3_idle", busy_b, 0);
      chk("b3_rows_left", q_row_b.size(), 0);
      chk("b3_done_left", q_done_b.size(), 0);
      repeat (2000) @(negedge clk);
      chk("b_frame_starts", fs_cnt_b, 3);
      chk("b_stays_idle", busy_b, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("a_rst_oe", oe_n_a, 1);
      chk("a_rst_outs", {rd_en_a, rd_addr_a, rgb_a, bclk_a, latch_a, row_addr_a, busy_a, fs_a, fd_a}, 0);
      chk("b_rst_oe", oe_n_b, 1);
      chk("b_rst_outs", {rd_en_b, rd_addr_b, rgb_b, bclk_b, latch_b, row_addr_b, busy_b, fs_b, fd_b}, 0);
      @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b0;
      fork
         run_a();
         run_b();
      join
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/led_display_bcm_driver.md
Name: led_display_bcm_driver

Overview:
- Parametrised successor to the single-bit HUB75 display driver PHY.
- Scans a NUM_ROW_PIXELS x NUM_COL_PIXELS panel with two half-panel data channels and binary-coded-modulation (BCM) colour depth.
- Fetches pixels from an external frame buffer over a fixed-latency read port.
- Sits between the pattern generator/frame buffer and the panel connector; per-plane display time is weighted 2^b for bit-plane b.

Parameters:
- SYS_CLK_FREQ, 100_000_000, system clock frequency (Hz); informational only, timing is set by the divisors below.
- NUM_ROW_PIXELS, 32, panel rows; must be even. SCAN_ROWS = NUM_ROW_PIXELS/2 (derived).
- NUM_COL_PIXELS, 64, panel columns; shifted per scan row.
- COLOUR_DEPTH, 4, bits per colour channel; number of BCM bit-planes, range 1..8.
- BCLK_DIV, 4, system clocks per bit-clock period; even, >= 2.
- BASE_ON_CYCLES, 16, OE-active cycles for bit-plane 0.
- LATCH_CYCLES, 2, system clocks latch_out is held high.

Ports:
- clk_in, in, 1, system clock.
- reset_in, in, 1, synchronous active-high reset.
- enable_in, in, 1, level; high = scan frames continuously.
- rd_en_out, out, 1, frame-buffer read strobe.
- rd_addr_out, out, clog2(SCAN_ROWS*NUM_COL_PIXELS), read address = row*NUM_COL_PIXELS + col.
- rd_data_in, in, 6*COLOUR_DEPTH, pixel pair {lower B,G,R, upper B,G,R}, each COLOUR_DEPTH wide, R in the LSBs. Valid exactly 1 cycle after rd_en_out.
- rgb_out, out, 6, {b1,g1,r1,b0,g0,r0}: bit b of each channel; 0 = upper half, 1 = lower half.
- bclk_out, out, 1, panel shift clock.
- latch_out, out, 1, panel latch.
- oe_n_out, out, 1, panel output enable, active low.
- row_addr_out, out, clog2(SCAN_ROWS), scan row address.
- busy_out, out, 1, high whenever not IDLE.
- frame_start_out, out, 1, one-cycle pulse at frame start.
- frame_done_out, out, 1, one-cycle pulse at frame end.

Behaviour:
- Reset (synchronous, takes effect on the next edge):
  - All outputs 0 except oe_n_out = 1.
  - FSM enters IDLE; row and plane counters clear.
  - Reset asserted mid-frame aborts immediately, with no partial latch.
- FSM states: IDLE, PREFETCH, SHIFT, BLANK, LATCH, DISPLAY.
- IDLE:
  - Outputs are at reset values.
  - If enable_in is sampled high, go to PREFETCH on the next cycle, with row=0, plane=0, and frame_start_out=1 during that PREFETCH cycle.
- PREFETCH (1 cycle):
  - rd_en_out=1, rd_addr_out = row*NUM_COL_PIXELS + 0.
  - Next state: SHIFT.
- SHIFT: phase counter p runs 0..BCLK_DIV-1 for each column c.
  - p=0: rgb_out is loaded from rd_data_in, selecting bit[plane] of each channel.
  - bclk_out=0 for p < BCLK_DIV/2, 1 otherwise.
  - At p=BCLK_DIV-1 with c < NUM_COL_PIXELS-1: rd_en_out=1 and address = next column.
  - After p=BCLK_DIV-1 of the last column, go to BLANK.
  - rgb_out holds its value outside p=0.
- BLANK (1 cycle):
  - bclk_out=0, oe_n_out=1.
  - On entry, row_addr_out updates to the current row; it is stable before latch rises.
- LATCH: latch_out=1 for LATCH_CYCLES cycles, then DISPLAY.
- DISPLAY:
  - oe_n_out=0 for exactly BASE_ON_CYCLES << plane cycles. The counter must be wide enough for BASE_ON_CYCLES << (COLOUR_DEPTH-1).
  - On completion, oe_n_out returns to 1 on the next cycle.
  - If plane < COLOUR_DEPTH-1: plane++, go to PREFETCH.
  - Else: plane=0 and row++. If row wraps past SCAN_ROWS-1, the frame ends.
- oe_n_out is 1 in every state except DISPLAY. latch_out and oe_n_out are never simultaneously active.
- Frame end:
  - frame_done_out=1 in the final DISPLAY cycle of row SCAN_ROWS-1, plane COLOUR_DEPTH-1.
  - If enable_in is high in that cycle, go directly to PREFETCH (row 0) with frame_start_out. Otherwise go to IDLE.
- enable_in deasserted mid-frame has no effect until frame end: frames are never truncated.
- Cycles per plane b = 1 + NUM_COL_PIXELS*BCLK_DIV + 1 + LATCH_CYCLES + (BASE_ON_CYCLES << b).

Test Plan:
- Small config (NUM_ROW=4, NUM_COL=4, DEPTH=2, BCLK_DIV=2, BASE=4, LATCH=1), enable held high:
  - frame_start_out pulses every 68 cycles.
  - frame_done_out pulses once per frame.
  - Per row, oe_n_out is low for 4 then 8 cycles.
- Same config, buffer word at addr r*4+c = pattern with upper R = c, lower B = r+1:
  - On each bclk_out rising edge, rgb_out matches bit[plane] of the expected values.
  - Exactly 4 rising edges per plane.
- Default config, single frame (enable high for 1 cycle):
  - 16 rows x 4 planes; row_addr_out steps 0..15.
  - busy_out falls the cycle after frame_done_out; returns to IDLE.
- Check 1-cycle read latency:
  - rd_en_out asserted exactly 64 times per plane.
  - rd_addr_out increments by 1 within the row.
  - rd_addr_out never exceeds 1023.
- Assert reset_in during DISPLAY of row 5:
  - Next cycle oe_n_out=1, all other outputs 0, FSM in IDLE.
  - With enable high, the restart begins at row 0.
- Deassert enable_in at row 3 plane 2: the frame completes through row 15, then IDLE; no further frame_start_out pulse.
